demux1_2_buf: RTL and testbench

- Buffered 1-to-2 router for a 32-bit datapath word stream. It is the steering counterpart of the core's 2:1 operand/result selects.
- Takes one valid/ready input stream and a per-word select bit. Steers each word into one of two independent output FIFOs, each with its own valid/ready handshake.
- Used where one producer feeds two consumers, e.g. a fetch/response stream split between the decode path and a side unit.
- Preserves order per output. Gives full throughput with registered outputs.

---
 rtl/demux1_2_buf.sv | 180 ++++++++++++++++++
 tb/tb_demux1_2_buf.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_2_buf.sv
// ---------------------------------------------------------------------------
// demux1_2_buf
//
// Buffered 1-to-2 router for a datapath word stream. One valid/ready producer
// stream is steered, word by word, into one of two independent output FIFOs
// by a per-word select bit. Each FIFO then presents its head entry to its
// own consumer on a separate valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset, clears both FIFOs
//   in_valid     input word present
//   in_ready     input word accepted this cycle when high with in_valid
//   in_data      input word
//   in_sel       0 steers the word to output A, 1 steers it to output B
//   out_a_valid  FIFO A head entry valid
//   out_a_ready  consumer A takes the head entry
//   out_a_data   FIFO A head entry (zero while A is empty)
//   out_b_valid  FIFO B head entry valid
//   out_b_ready  consumer B takes the head entry
//   out_b_data   FIFO B head entry (zero while B is empty)
//   out_a_count  occupancy of FIFO A, 0..DEPTH
//   out_b_count  occupancy of FIFO B, 0..DEPTH
//
// The output data paths come straight from FIFO storage, so there is never a
// combinational path from in_data to either out_*_data.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// demux1_2_buf_fifo
//
// Single circular-buffer FIFO used for each output leg.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   push        write push_data this cycle (ignored when full)
//   push_data   word to store
//   pop_ready   consumer takes the head entry when valid
//   valid       FIFO holds at least one entry
//   data        head entry, forced to zero when empty
//   count       current occupancy, 0..DEPTH
//   full        occupancy equals DEPTH
// ---------------------------------------------------------------------------
module demux1_2_buf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_ready,
  output logic                       valid,
  output logic [WIDTH-1:0]           data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Full/valid come only from the registered count, so a pop in this cycle
  // never opens a slot for a push in the same cycle.
  assign full    = (cnt == CNT_FULL);
  assign valid   = (cnt != '0);
  assign do_push = push & ~full;
  assign do_pop  = valid & pop_ready;
  assign count   = cnt;

  // Head entry is masked to zero while empty so stale storage never leaks.
  assign data = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers wrap modulo DEPTH by plain binary overflow. A simultaneous push
  // and pop moves both pointers and leaves the count where it was.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not cleared on reset; the count masks every entry instead.
  // A write presented during reset is dropped along with the rest of the
  // transfer.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

module demux1_2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sel,
  output logic                   out_a_valid,
  input  logic                   out_a_ready,
  output logic [WIDTH-1:0]       out_a_data,
  output logic                   out_b_valid,
  input  logic                   out_b_ready,
  output logic [WIDTH-1:0]       out_b_data,
  output logic [$clog2(DEPTH):0] out_a_count,
  output logic [$clog2(DEPTH):0] out_b_count
);

  logic full_a;
  logic full_b;
  logic push_a;
  logic push_b;

  // Ready depends only on the selected FIFO. A full target stalls the input
  // even when the other FIFO has room, so words never overtake each other.
  assign in_ready = in_sel ? ~full_b : ~full_a;

  assign push_a = in_valid & in_ready & ~in_sel;
  assign push_b = in_valid & in_ready &  in_sel;

  demux1_2_buf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_a),
    .push_data (in_data),
    .pop_ready (out_a_ready),
    .valid     (out_a_valid),
    .data      (out_a_data),
    .count     (out_a_count),
    .full      (full_a)
  );

  demux1_2_buf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_b),
    .push_data (in_data),
    .pop_ready (out_b_ready),
    .valid     (out_b_valid),
    .data      (out_b_data),
    .count     (out_b_count),
    .full      (full_b)
  );

endmodule

// File: tb/tb_demux1_2_buf.sv
// ---------------------------------------------------------------------------
// tb_demux1_2_buf
//
// Directed bench for demux1_2_buf with WIDTH=32, DEPTH=2. Inputs change 1ns
// after each rising edge; outputs are inspected before the next edge. A
// negedge monitor watches occupancy bounds, valid/count agreement and the
// producer hold rule while stalled.
// ---------------------------------------------------------------------------
module tb_demux1_2_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        out_a_valid;
  logic        out_a_ready;
  logic [31:0] out_a_data;
  logic        out_b_valid;
  logic        out_b_ready;
  logic [31:0] out_b_data;
  logic [1:0]  out_a_count;
  logic [1:0]  out_b_count;

  int compareCount = 0;
  int failCount    = 0;

  demux1_2_buf #(
    .WIDTH (32),
    .DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_a_data  (out_a_data),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .out_b_data  (out_b_data),
    .out_a_count (out_a_count),
    .out_b_count (out_b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on a miss counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive all producer/consumer inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic s, input logic ra, input logic rb);
    in_valid    = v;
    in_data     = d;
    in_sel      = s;
    out_a_ready = ra;
    out_b_ready = rb;
    #1;
  endtask

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariant monitor: bounded occupancy, valid tracks count, and a stalled
  // producer keeps its word, select and valid unchanged.
  logic        prevStall;
  logic [31:0] prevData;
  logic        prevSel;

  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall = 1'b0;
    end else begin
      checkOutput("inv_cnt_a_le_depth", 32'(out_a_count > 2'd2), 32'd0);
      checkOutput("inv_cnt_b_le_depth", 32'(out_b_count > 2'd2), 32'd0);
      checkOutput("inv_a_valid_count", 32'(out_a_valid), 32'(out_a_count != 2'd0));
      checkOutput("inv_b_valid_count", 32'(out_b_valid), 32'(out_b_count != 2'd0));
      if (prevStall) begin
        checkOutput("inv_hold_valid", 32'(in_valid), 32'd1);
        checkOutput("inv_hold_data", in_data, prevData);
        checkOutput("inv_hold_sel", 32'(in_sel), 32'(prevSel));
      end
      prevStall = in_valid && !in_ready;
      prevData  = in_data;
      prevSel   = in_sel;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int ia;
    int ib;
    int iw;
    int cyc;
    logic accepted;

    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Idle after reset: everything empty, input ready for either select.
    checkOutput("rst_a_valid", 32'(out_a_valid), 32'd0);
    checkOutput("rst_b_valid", 32'(out_b_valid), 32'd0);
    checkOutput("rst_a_count", 32'(out_a_count), 32'd0);
    checkOutput("rst_b_count", 32'(out_b_count), 32'd0);
    checkOutput("rst_a_data", out_a_data, 32'h0);
    checkOutput("rst_b_data", out_b_data, 32'h0);
    checkOutput("rst_in_ready_sel0", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_in_ready_sel1", 32'(in_ready), 32'd1);

    // Reset while both FIFOs hold an entry; the push offered during reset is
    // discarded.
    applyStimulus(1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hC3C3C3C3, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_a_count", 32'(out_a_count), 32'd1);
    checkOutput("pre_rst_b_count", 32'(out_b_count), 32'd1);
    checkOutput("pre_rst_a_data", out_a_data, 32'h5A5A5A5A);
    checkOutput("pre_rst_b_data", out_b_data, 32'hC3C3C3C3);
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst_a_count", 32'(out_a_count), 32'd0);
    checkOutput("mid_rst_b_count", 32'(out_b_count), 32'd0);
    checkOutput("mid_rst_a_valid", 32'(out_a_valid), 32'd0);
    checkOutput("mid_rst_b_valid", 32'(out_b_valid), 32'd0);
    checkOutput("mid_rst_a_data", out_a_data, 32'h0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);

    // Steering and one-cycle latency with both consumers always ready.
    applyStimulus(1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1);
    checkOutput("route_c2_a_valid", 32'(out_a_valid), 32'd1);
    checkOutput("route_c2_a_data", out_a_data, 32'h11111111);
    checkOutput("route_c2_b_valid", 32'(out_b_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("route_c3_a_valid", 32'(out_a_valid), 32'd0);
    checkOutput("route_c3_b_valid", 32'(out_b_valid), 32'd1);
    checkOutput("route_c3_b_data", out_b_data, 32'h22222222);
    tick();
    checkOutput("route_c4_b_valid", 32'(out_b_valid), 32'd0);
    checkOutput("route_c4_b_count", 32'(out_b_count), 32'd0);

    // Fill A while consumer A stalls; the third A word must wait.
    applyStimulus(1'b1, 32'hA0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("full_a_count", 32'(out_a_count), 32'd2);
    checkOutput("full_ready_sel1", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0, 1'b1);
    checkOutput("full_ready_sel0", 32'(in_ready), 32'd0);
    tick();
    applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0, 1'b1);
    checkOutput("held_a_count", 32'(out_a_count), 32'd2);
    checkOutput("held_a_head", out_a_data, 32'hA0);
    checkOutput("held_b_count", 32'(out_b_count), 32'd0);

    // Full A with a pop and a new A word in the same cycle: pop only.
    applyStimulus(1'b1, 32'hA2, 1'b0, 1'b1, 1'b1);
    checkOutput("popfull_ready", 32'(in_ready), 32'd0);
    checkOutput("pop0_data", out_a_data, 32'hA0);
    tick();
    checkOutput("popfull_a_count", 32'(out_a_count), 32'd1);
    checkOutput("pop1_data", out_a_data, 32'hA1);
    checkOutput("popfull_ready_after", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("pushpop_a_count", 32'(out_a_count), 32'd1);
    checkOutput("pop2_data", out_a_data, 32'hA2);
    tick();
    checkOutput("drain_a_count", 32'(out_a_count), 32'd0);
    checkOutput("drain_a_valid", 32'(out_a_valid), 32'd0);

    // Push to B while popping A, both at occupancy one.
    applyStimulus(1'b1, 32'h0000C0DE, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000B001, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000B002, 1'b1, 1'b1, 1'b0);
    checkOutput("cross_pre_a_count", 32'(out_a_count), 32'd1);
    checkOutput("cross_pre_b_count", 32'(out_b_count), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("cross_a_count", 32'(out_a_count), 32'd0);
    checkOutput("cross_b_count", 32'(out_b_count), 32'd2);
    checkOutput("cross_a_valid", 32'(out_a_valid), 32'd0);
    checkOutput("cross_b_head", out_b_data, 32'h0000B001);
    tick();
    checkOutput("cross_b_next", out_b_data, 32'h0000B002);
    tick();
    checkOutput("cross_b_empty", 32'(out_b_count), 32'd0);

    // Stream 0..7 with alternating select under random consumer backpressure.
    ia  = 0;
    ib  = 0;
    iw  = 0;
    cyc = 0;
    while ((ia < 4 || ib < 4) && cyc < 300) begin
      applyStimulus(iw < 8, 32'(iw), iw[0],
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      accepted = in_valid && in_ready;
      if (out_a_valid && out_a_ready) begin
        checkOutput("stream_a", out_a_data, 32'(2 * ia));
        ia++;
      end
      if (out_b_valid && out_b_ready) begin
        checkOutput("stream_b", out_b_data, 32'(2 * ib + 1));
        ib++;
      end
      tick();
      if (accepted) iw++;
      cyc++;
    end
    checkOutput("stream_a_total", 32'(ia), 32'd4);
    checkOutput("stream_b_total", 32'(ib), 32'd4);
    checkOutput("stream_sent", 32'(iw), 32'd8);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_a_left", 32'(out_a_count), 32'd0);
    checkOutput("stream_b_left", 32'(out_b_count), 32'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
